// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: deframer state encoding and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_fifo_pkg;

   // 12 MHz core clock / 9600 baud
   localparam int RX_CLKS_PER_BIT_DEF = 1250;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   // Even parity over data plus parity bit: a nonzero XOR means the character is corrupt
   function automatic logic even_parity_bad(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with async reset clear; shared by UART rx and tx paths.
// Latency: a pushed word is visible on dout the edge after the push; pop advances the head on the next edge.
// Backpressure: push is ignored when full unless a pop happens the same cycle; pop is ignored when empty.
module uart_rx_fifo_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_rd;
   logic             do_wr;

   // a full FIFO still takes a word when the head leaves in the same cycle
   assign do_rd = pop & ~empty;
   assign do_wr = push & (~full | do_rd);

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign dout  = empty ? '0 : mem[rd_ptr];

   // pointers wrap naturally because DEPTH is a power of two; count is the occupancy reference
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage carries no reset; stale words are never visible because dout is masked when empty
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive front-end: rx synchronizer, 8N1 deframer (parity when UART_RX_PARITY_EN is defined), byte FIFO, sticky flags.
// Latency: byte lands in the FIFO ~4 clk after the stop bit mid-point (2-FF sync, edge detect, push register).
// Backpressure: none on the serial line; a byte arriving while the FIFO is full is dropped and overrun is set.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int CLKS_PER_BIT = RX_CLKS_PER_BIT_DEF,
   parameter int DEPTH        = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rx,
   input  logic                       rd_en,
   output logic [7:0]                 dout,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       rx_flag,
   input  logic                       rx_flag_clr,
   output logic                       overrun,
   output logic                       frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                       parity_err,
`endif
   input  logic                       err_clr
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic          rx_meta;
   logic          rx_s;
   logic          rx_prev;
   logic          rx_fall;
   rx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          push_req;
   logic [7:0]    push_dat;
   logic          ferr_evt;
`ifdef UART_RX_PARITY_EN
   logic          par_bit;
   logic          perr_evt;
`endif
   logic          pop;
   logic          push_ok;

   // two-flop synchronizer plus one history flop for start-edge detection; idles high out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // a held-low line produces no new edge, so a break reports one frame error and then waits for high
   assign rx_fall = rx_prev & ~rx_s;

   // deframer: half-bit wait into START, then mid-bit samples; leaves STOP mid-bit to catch back-to-back frames
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RX_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         push_req <= 1'b0;
         push_dat <= '0;
         ferr_evt <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit  <= 1'b0;
         perr_evt <= 1'b0;
`endif
      end else begin
         push_req <= 1'b0;
         ferr_evt <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_evt <= 1'b0;
`endif
         case (state)
            RX_IDLE: begin
               if (rx_fall) begin
                  state <= RX_START;
                  cnt   <= '0;
               end
            end
            RX_START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     state   <= RX_DATA;
                     bit_idx <= '0;
                  end else begin
                     state <= RX_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= RX_PARITY;
`else
                     state <= RX_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  par_bit <= rx_s;
                  state   <= RX_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            RX_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt      <= '0;
                  state    <= RX_IDLE;
                  push_dat <= shreg;
                  ferr_evt <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                  perr_evt <= even_parity_bad(shreg, par_bit);
                  push_req <= rx_s & ~even_parity_bad(shreg, par_bit);
`else
                  push_req <= rx_s;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

   assign pop     = rd_en & ~empty;
   assign push_ok = push_req & (~full | pop);

   uart_rx_fifo_sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_ok),
      .din   (push_dat),
      .pop   (pop),
      .dout  (dout),
      .empty (empty),
      .full  (full),
      .count (count)
   );

   // sticky status flags; a set in the same cycle as a clear wins so no event is lost
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_flag    <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         if (push_ok)                 rx_flag <= 1'b1;
         else if (rx_flag_clr)        rx_flag <= 1'b0;
         if (push_req && !push_ok)    overrun <= 1'b1;
         else if (err_clr)            overrun <= 1'b0;
         if (ferr_evt)                frame_err <= 1'b1;
         else if (err_clr)            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         if (perr_evt)                parity_err <= 1'b1;
         else if (err_clr)            parity_err <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven bit by bit, checked against a byte-queue model of the receiver.
// Latency: checks are taken a few cycles after each frame ends, not cycle-exact.
// Backpressure: the model drops bytes and raises overrun when its queue already holds DEPTH bytes.
module tb_uart_rx_fifo;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       rd_en = 1'b0;
   logic       rx_flag_clr = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] dout;
   logic       empty;
   logic       full;
   logic [2:0] count;
   logic       rx_flag;
   logic       overrun;
   logic       frame_err;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
   logic       flip_par = 1'b0;
   logic       m_perr = 1'b0;
`endif

   int         total = 0;
   int         bad = 0;
   logic [7:0] q[$];
   logic       m_flag = 1'b0;
   logic       m_ovr = 1'b0;
   logic       m_ferr = 1'b0;
   logic       seen;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .rd_en       (rd_en),
      .dout        (dout),
      .empty       (empty),
      .full        (full),
      .count       (count),
      .rx_flag     (rx_flag),
      .rx_flag_clr (rx_flag_clr),
      .overrun     (overrun),
      .frame_err   (frame_err),
`ifdef UART_RX_PARITY_EN
      .parity_err  (parity_err),
`endif
      .err_clr     (err_clr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_state(input string tag);
      logic [31:0] exp_dout;
      exp_dout = (q.size() > 0) ? 32'(q[0]) : 32'd0;
      check({tag, ".count"},     32'(count),     32'(q.size()));
      check({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
      check({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
      check({tag, ".dout"},      32'(dout),      exp_dout);
      check({tag, ".rx_flag"},   32'(rx_flag),   32'(m_flag));
      check({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
      check({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
`ifdef UART_RX_PARITY_EN
      check({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
`endif
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // drives start, data LSB first, optional parity, stop; nbits truncates the frame
   task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
      logic bits [11];
      int   n;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef UART_RX_PARITY_EN
      bits[9]  = (^d) ^ flip_par;
      bits[10] = stop;
      n = 11;
`else
      bits[9]  = stop;
      bits[10] = 1'b1;
      n = 10;
`endif
      if (nbits < n) n = nbits;
      for (int i = 0; i < n; i++) begin
         rx = bits[i];
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
      if (!stop) repeat (CPB) @(negedge clk);
   endtask

   // full frame plus the receiver's expected reaction
   task automatic send_byte(input logic [7:0] d, input logic stop_ok);
      logic ok;
      send_frame(d, stop_ok, 99);
      ok = stop_ok;
`ifdef UART_RX_PARITY_EN
      if (flip_par) begin
         m_perr = 1'b1;
         ok = 1'b0;
      end
`endif
      if (!stop_ok) m_ferr = 1'b1;
      if (ok) begin
         if (q.size() < DEPTH) begin
            q.push_back(d);
            m_flag = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end
   endtask

   task automatic pop_byte();
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
   endtask

   task automatic err_clear();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
      m_perr = 1'b0;
`endif
   endtask

   task automatic flag_clear();
      rx_flag_clr = 1'b1;
      @(negedge clk);
      rx_flag_clr = 1'b0;
      m_flag = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] d;
      int         np;

      repeat (2) @(negedge clk);
      check_state("reset");
      rst = 1'b0;
      idle(2 * CPB);

      // single character then pop
      send_byte(8'hA5, 1'b1);
      idle(4);
      check_state("a5");
      pop_byte();
      check_state("a5_pop");
      flag_clear();

      // back-to-back characters
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h3C, 1'b1);
      idle(4);
      check_state("b2b");
      for (int i = 0; i < 3; i++) begin
         pop_byte();
         check_state("b2b_pop");
      end

      // overflow: fifth byte dropped
      for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b1);
      idle(4);
      check_state("ovr");
      err_clear();
      check_state("ovr_clr");
      while (q.size() > 0) pop_byte();
      check_state("ovr_drain");

      // bad stop bit, then a one-cycle glitch on the idle line
      send_byte(8'h55, 1'b0);
      idle(4);
      check_state("ferr");
      err_clear();
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      idle(3 * CPB);
      check_state("glitch");

      // clear coinciding with push: set must win
      flag_clear();
      rx_flag_clr = 1'b1;
      seen = 1'b0;
      fork
         send_byte(8'h5A, 1'b1);
         begin
            for (int k = 0; k < 20 * CPB && !seen; k++) begin
               @(posedge clk);
               #1;
               if (!empty) begin
                  rx_flag_clr = 1'b0;
                  seen = 1'b1;
               end
            end
            rx_flag_clr = 1'b0;
         end
      join
      check("clr_push_wait", 32'(seen), 32'd1);
      check("flag_set_wins", 32'(rx_flag), 32'd1);
      flag_clear();
      check_state("flag_clr");
      pop_byte();

      // randomized traffic
      for (int it = 0; it < 14; it++) begin
         d = 8'($urandom);
         send_byte(d, ($urandom_range(0, 5) != 0));
         idle(4);
         np = $urandom_range(0, 2);
         for (int p = 0; p < np; p++) pop_byte();
         if ($urandom_range(0, 3) == 0) err_clear();
         if ($urandom_range(0, 3) == 0) flag_clear();
         check_state("rnd");
      end

      // reset in the middle of a data field
      send_byte(8'h11, 1'b1);
      send_frame(8'h81, 1'b1, 4);
      rst = 1'b1;
      rx  = 1'b1;
      #1;
      q.delete();
      m_flag = 1'b0;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
      m_perr = 1'b0;
`endif
      check_state("rst_mid");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(2 * CPB);
      check_state("rst_after");
      send_byte(8'h42, 1'b1);
      idle(4);
      check_state("rx_42");

`ifdef UART_RX_PARITY_EN
      // 0x03 carries even parity bit 0; sending 1 must be rejected
      flip_par = 1'b1;
      send_byte(8'h03, 1'b1);
      flip_par = 1'b0;
      idle(4);
      check_state("par_err");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
